// File: rtl/dual_stream_merge.sv
// dual_stream_merge
//
// Merges the valid/data outputs of two parallel global-stall pipelines into
// one registered valid/ready stream. Each source has its own FIFO, and a
// round-robin arbiter feeds a single output holding register. The upstream
// stall is raised from registered FIFO occupancy early enough that a
// well-behaved upstream never overflows a FIFO.
//
// Ports
//   clk         sole clock, rising edge
//   reset       asynchronous active-low reset
//   in_data_1   pipeline 1 data            in_valid_1  pipeline 1 valid
//   in_data_2   pipeline 2 data            in_valid_2  pipeline 2 valid
//   stall       global stall request to both pipelines
//   out_data    merged data                out_src     0 = pipeline 1, 1 = pipeline 2
//   out_valid   out_data/out_src valid     out_ready   consumer ready
//   overflow    sticky: a valid input word was dropped
//   count_1     words delivered from pipeline 1 (mod 2^16)
//   count_2     words delivered from pipeline 2 (mod 2^16)
//
// Handshake: a word transfers on a rising edge where out_valid & out_ready.
// While out_valid & !out_ready, out_data/out_src hold steady. The inputs have
// no ready; in_valid_k alone presents a word, and stall is the only
// backpressure toward the pipelines.

module dual_stream_merge #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 4,
    parameter int STALL_TH = DEPTH - 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data_1,
    input  logic             in_valid_1,
    input  logic [WIDTH-1:0] in_data_2,
    input  logic             in_valid_2,
    output logic             stall,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow,
    output logic [15:0]      count_1,
    output logic [15:0]      count_2
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] TH_C    = CW'(STALL_TH);

    // FIFO storage and pointers
    logic [WIDTH-1:0] mem1_q [DEPTH];
    logic [WIDTH-1:0] mem2_q [DEPTH];
    logic [AW-1:0]    wp1_q, wp1_d, rp1_q, rp1_d;
    logic [AW-1:0]    wp2_q, wp2_d, rp2_q, rp2_d;
    logic [CW-1:0]    occ1_q, occ1_d, occ2_q, occ2_d;

    // Output holding register and bookkeeping
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_src_q, out_src_d;
    logic             last_src_q, last_src_d;
    logic             overflow_q, overflow_d;
    logic [15:0]      cnt1_q, cnt1_d, cnt2_q, cnt2_d;

    logic ne1, ne2, free, load, grant_src;
    logic pop1, pop2, push1, push2, fire;

    assign ne1  = (occ1_q != '0);
    assign ne2  = (occ2_q != '0);
    assign free = !out_valid_q || out_ready;
    assign load = free && (ne1 || ne2);
    assign fire = out_valid_q && out_ready;

    // Round-robin: with both FIFOs non-empty, serve the source that lost last.
    // last_src_q resets to 1 so pipeline 1 wins the first tie.
    always_comb begin
        grant_src = 1'b0;
        if (ne1 && ne2) begin
            grant_src = ~last_src_q;
        end else if (ne2) begin
            grant_src = 1'b1;
        end
    end

    assign pop1 = load && !grant_src;
    assign pop2 = load && grant_src;

    // A full FIFO still accepts a word when it is popped on the same edge.
    assign push1 = in_valid_1 && ((occ1_q != DEPTH_C) || pop1);
    assign push2 = in_valid_2 && ((occ2_q != DEPTH_C) || pop2);

    always_comb begin
        wp1_d       = wp1_q;
        rp1_d       = rp1_q;
        wp2_d       = wp2_q;
        rp2_d       = rp2_q;
        occ1_d      = occ1_q + CW'(push1) - CW'(pop1);
        occ2_d      = occ2_q + CW'(push2) - CW'(pop2);
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        last_src_d  = last_src_q;
        overflow_d  = overflow_q;
        cnt1_d      = cnt1_q;
        cnt2_d      = cnt2_q;

        if (push1) wp1_d = wp1_q + AW'(1);
        if (push2) wp2_d = wp2_q + AW'(1);
        if (pop1)  rp1_d = rp1_q + AW'(1);
        if (pop2)  rp2_d = rp2_q + AW'(1);

        if ((in_valid_1 && !push1) || (in_valid_2 && !push2)) begin
            overflow_d = 1'b1;
        end

        if (free) begin
            out_valid_d = load;
            if (load) begin
                out_data_d = grant_src ? mem2_q[rp2_q] : mem1_q[rp1_q];
                out_src_d  = grant_src;
                last_src_d = grant_src;
            end
        end

        if (fire && !out_src_q) cnt1_d = cnt1_q + 16'd1;
        if (fire && out_src_q)  cnt2_d = cnt2_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp1_q       <= '0;
            rp1_q       <= '0;
            wp2_q       <= '0;
            rp2_q       <= '0;
            occ1_q      <= '0;
            occ2_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 1'b0;
            last_src_q  <= 1'b1;
            overflow_q  <= 1'b0;
            cnt1_q      <= '0;
            cnt2_q      <= '0;
        end else begin
            wp1_q       <= wp1_d;
            rp1_q       <= rp1_d;
            wp2_q       <= wp2_d;
            rp2_q       <= rp2_d;
            occ1_q      <= occ1_d;
            occ2_q      <= occ2_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            last_src_q  <= last_src_d;
            overflow_q  <= overflow_d;
            cnt1_q      <= cnt1_d;
            cnt2_q      <= cnt2_d;
        end
    end

    // Storage needs no reset: pointers and occupancy define what is live.
    always_ff @(posedge clk) begin
        if (push1) mem1_q[wp1_q] <= in_data_1;
        if (push2) mem2_q[wp2_q] <= in_data_2;
    end

    // Registered occupancy only, so no combinational path from the inputs.
    assign stall     = (occ1_q >= TH_C) || (occ2_q >= TH_C);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign overflow  = overflow_q;
    assign count_1   = cnt1_q;
    assign count_2   = cnt2_q;

endmodule

// File: tb/tb_dual_stream_merge.sv
module tb_dual_stream_merge;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  in_data_1, in_data_2;
    logic          in_valid_1, in_valid_2;
    logic          stall;
    logic [W-1:0]  out_data;
    logic          out_src;
    logic          out_valid;
    logic          out_ready;
    logic          overflow;
    logic [15:0]   count_1, count_2;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W:0] exp_q[$];
    logic       saw_stall;
    int         n;

    dual_stream_merge #(.WIDTH(W), .DEPTH(4), .STALL_TH(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data_1  (in_data_1),
        .in_valid_1 (in_valid_1),
        .in_data_2  (in_data_2),
        .in_valid_2 (in_valid_2),
        .stall      (stall),
        .out_data   (out_data),
        .out_src    (out_src),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overflow   (overflow),
        .count_1    (count_1),
        .count_2    (count_2)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // scoreboard: every accepted output word must match the queue head
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_word", 64'(exp_q.size()), 64'd1);
            end else begin
                check("sb_word", 64'({out_src, out_data}), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid_1 = 1'b0;
        in_valid_2 = 1'b0;
        in_data_1  = '0;
        in_data_2  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        out_ready = 1'b0;
        reset = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        tick();
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || out_valid) && k < 60) begin
            tick();
            k++;
        end
        if (k >= 60) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        idle_inputs();
        out_ready = 1'b0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_stall",     64'(stall), 0);
        check("rst_overflow",  64'(overflow), 0);
        check("rst_out_data",  64'(out_data), 0);
        check("rst_counts",    64'({count_1, count_2}), 0);

        // single source, 5/6/7
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid_1 = 1'b1;
            in_data_1  = W'(5 + i);
            exp_q.push_back({1'b0, in_data_1});
            tick();
            if (i == 0) check("s1_valid_edge1", 64'(out_valid), 0);
            if (i == 1) begin
                check("s1_valid_edge2", 64'(out_valid), 1);
                check("s1_data_edge2",  64'(out_data), 5);
                check("s1_src_edge2",   64'(out_src), 0);
            end
            check("s1_stall", 64'(stall), 0);
        end
        idle_inputs();
        tick();
        check("s1_stall_tail", 64'(stall), 0);
        wait_drain();
        check("s1_count_1", 64'(count_1), 3);
        check("s1_count_2", 64'(count_2), 0);

        // fair merge, inputs honour stall
        do_reset();
        out_ready = 1'b1;
        saw_stall = 1'b0;
        n = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (!stall && n < 12) begin
                in_valid_1 = 1'b1;
                in_valid_2 = 1'b1;
                in_data_1  = W'(100 + n);
                in_data_2  = W'(200 + n);
                exp_q.push_back({1'b0, in_data_1});
                exp_q.push_back({1'b1, in_data_2});
                n++;
            end else begin
                idle_inputs();
            end
            tick();
            if (stall) saw_stall = 1'b1;
            if (cyc == 0) check("fm_stall_edge1", 64'(stall), 0);
            if (cyc == 1) check("fm_stall_edge2", 64'(stall), 1);
        end
        idle_inputs();
        wait_drain();
        check("fm_saw_stall", 64'(saw_stall), 1);
        check("fm_overflow",  64'(overflow), 0);
        check("fm_count_1",   64'(count_1), 12);
        check("fm_count_2",   64'(count_2), 12);

        // backpressure and overflow, stall ignored
        do_reset();
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            in_valid_1 = 1'b1;
            in_data_1  = W'(i);
            if (i <= 5) exp_q.push_back({1'b0, in_data_1});
            tick();
            if (i == 2) begin
                check("bp_data_edge2",  64'(out_data), 1);
                check("bp_stall_edge2", 64'(stall), 0);
            end
            if (i == 3) check("bp_stall_edge3", 64'(stall), 1);
            if (i == 5) check("bp_ovf_edge5",   64'(overflow), 0);
            if (i == 6) begin
                check("bp_ovf_edge6",   64'(overflow), 1);
                check("bp_hold_edge6",  64'(out_data), 1);
                check("bp_valid_edge6", 64'(out_valid), 1);
            end
        end
        idle_inputs();
        out_ready = 1'b1;
        wait_drain();
        check("bp_count_1",    64'(count_1), 5);
        check("bp_ovf_sticky", 64'(overflow), 1);

        // async reset with traffic in flight
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid_1 = 1'b1;
            in_data_1  = W'(32'h40 + i);
            tick();
        end
        idle_inputs();
        check("ar_pre_valid", 64'(out_valid), 1);
        check("ar_pre_stall", 64'(stall), 1);
        check("ar_pre_count", 64'(count_1), 5);
        #2;
        reset = 1'b0;
        exp_q.delete();
        #1;
        check("ar_valid",    64'(out_valid), 0);
        check("ar_stall",    64'(stall), 0);
        check("ar_overflow", 64'(overflow), 0);
        check("ar_counts",   64'({count_1, count_2}), 0);
        check("ar_data",     64'(out_data), 0);
        #2;
        reset = 1'b1;
        repeat (3) tick();
        check("ar_post_valid", 64'(out_valid), 0);
        check("ar_post_stall", 64'(stall), 0);
        check("ar_post_ovf",   64'(overflow), 0);
        check("ar_post_src",   64'(out_src), 0);
        check("ar_post_cnt",   64'({count_1, count_2}), 0);

        // full FIFO with a simultaneous pop accepts the push
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid_1 = 1'b1;
            in_data_1  = W'(32'h10 + i);
            exp_q.push_back({1'b0, in_data_1});
            tick();
        end
        check("fp_full_stall", 64'(stall), 1);
        check("fp_full_data",  64'(out_data), 32'h10);
        check("fp_full_ovf",   64'(overflow), 0);
        out_ready = 1'b1;
        in_data_1 = 32'hABCD;
        exp_q.push_back({1'b0, in_data_1});
        tick();
        check("fp_pop_ovf",   64'(overflow), 0);
        check("fp_pop_data",  64'(out_data), 32'h11);
        check("fp_pop_stall", 64'(stall), 1);
        out_ready = 1'b0;
        in_data_1 = 32'h5555;
        tick();
        check("fp_still_full_drop", 64'(overflow), 1);
        idle_inputs();
        out_ready = 1'b1;
        wait_drain();
        check("fp_count_1", 64'(count_1), 6);

        // counter wrap on pipeline 2
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            in_valid_2 = 1'b1;
            in_data_2  = W'(i);
            exp_q.push_back({1'b1, in_data_2});
            tick();
        end
        idle_inputs();
        wait_drain();
        check("cw_count_2_max", 64'(count_2), 16'hFFFF);
        check("cw_count_1_max", 64'(count_1), 0);
        in_valid_2 = 1'b1;
        in_data_2  = 32'hFFFF_0000;
        exp_q.push_back({1'b1, in_data_2});
        tick();
        idle_inputs();
        wait_drain();
        check("cw_count_2_wrap", 64'(count_2), 0);
        check("cw_count_1_wrap", 64'(count_1), 0);
        check("cw_overflow",     64'(overflow), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dual_stream_merge.md
# dual_stream_merge

Downstream consumer of the two parallel global-stall pipelines. Takes each pipeline's valid/data output, buffers it in a per-source FIFO, and round-robin merges both streams into one registered valid/ready output stream tagged with its source. Drives the pipelines' global stall before either FIFO can overflow, and keeps per-source delivery counters plus a sticky overflow flag for debug.

## Interface
- WIDTH, 32, data width of each input stream and of the output.
- DEPTH, 4, entries per source FIFO; power of two, >= 4.
- STALL_TH, DEPTH-2, per-FIFO occupancy at or above which stall is asserted.

- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low; low clears all state immediately.
- in_data_1  in  WIDTH  pipeline 1 data.
- in_valid_1  in  1  pipeline 1 data valid.
- in_data_2  in  WIDTH  pipeline 2 data.
- in_valid_2  in  1  pipeline 2 data valid.
- stall  out  1  global stall request to both pipelines.
- out_data  out  WIDTH  merged data.
- out_src  out  1  source of out_data: 0 = pipeline 1, 1 = pipeline 2.
- out_valid  out  1  out_data/out_src valid.
- out_ready  in  1  consumer accepts when out_valid & out_ready at a rising edge.
- overflow  out  1  sticky: a valid input word was dropped.
- count_1  out  16  words delivered from pipeline 1, wraps mod 2^16.
- count_2  out  16  words delivered from pipeline 2, wraps mod 2^16.

## Operation
- Reset (reset low, async): FIFOs emptied, in-flight words discarded; out_valid 0, out_data 0, out_src 0, stall 0, overflow 0, count_1/count_2 0, round-robin pointer set so pipeline 1 wins first tie.
- Push: at each edge, in_valid_k = 1 writes in_data_k into FIFO k if occupancy_k < DEPTH or FIFO k is popped the same edge. Otherwise the word is dropped and overflow sets; overflow clears only on reset.
- Output register: a single holding stage (out_valid/out_data/out_src). It is "free" when out_valid = 0 or out_valid & out_ready. When free and at least one FIFO is non-empty, it loads the head of the granted FIFO at that edge. When free and both FIFOs are empty, out_valid goes 0.
- Arbitration: only one FIFO non-empty means that FIFO is granted. Both non-empty means the source not granted last time is granted. The pointer updates only on a grant.
- Holding: while out_valid & !out_ready, out_data/out_src are stable and no pop occurs.
- Counters: count_k increments on out_valid & out_ready with out_src = k-1, and wraps from 65535 to 0.
- stall = (occupancy_1 >= STALL_TH) | (occupancy_2 >= STALL_TH). It is combinational from registered occupancies only; there is no path from in_* or out_ready to stall.
- Headroom: the upstream responds to stall at the next edge, so one further word per source may arrive after stall rises. The STALL_TH = DEPTH-2 setting guarantees no drop when the upstream obeys stall.

## Timing
- Latency: a word pushed at edge N is eligible for the output register at edge N+1, so out_valid is high in the cycle after N+1 when the path is unobstructed. There is no same-cycle bypass.
- Throughput: one word per cycle total across both sources with out_ready held high.
- stall changes in the same cycle occupancy changes (right after the edge).
- Simultaneous push and pop on the same FIFO: occupancy unchanged; when full, the push is accepted.
- Simultaneous valid on both inputs: both are pushed (separate FIFOs), then served alternately.
- Reset asserted mid-transfer: outputs drop to reset values without waiting for clk. After reset rises, the first push behaves as from empty.

## Test plan
- Async reset: with traffic flowing and out_valid = 1, drive reset low between edges -> out_valid, stall, overflow, counts read 0 before the next edge. Release reset -> all stay 0 until new input.
- Single source: out_ready = 1, in_valid_1 with 5, 6, 7 on edges 1-3 -> out_valid first high after edge 2, outputs 5/6/7 with out_src 0, count_1 = 3, count_2 = 0, stall never high.
- Fair merge: both valid every cycle, data 100+i and 200+i, out_ready = 1 -> output sequence 100, 200, 101, 201, ... with alternating out_src. stall rises when either occupancy reaches 2, and no overflow occurs if inputs honour stall.
- Backpressure/overflow: out_ready = 0, in_valid_1 words 1..6 on edges 1-6, stall ignored -> out_data holds 1, stall high after edge 3, word 6 dropped, overflow = 1. Release out_ready -> 1..5 delivered in order, count_1 = 5.
- Full with pop: FIFO 1 full, out_valid = 1, one cycle with out_ready = 1 and in_valid_1 = 1 (data 0xABCD) -> word accepted, overflow stays 0, occupancy stays DEPTH. 0xABCD is later delivered last.
- Counter wrap: 65536 deliveries from pipeline 2 -> count_2 returns to 0 and count_1 is unchanged.
